// File: rtl/cpu_program_sequencer_pkg.sv
// Shared definitions for the program sequencer: opcodes, FSM encoding and
// instruction field positions.
package cpu_program_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_FETCH_IMM, S_ISSUE, S_EXEC, S_HALTED, S_ERROR
  } seq_state_e;

  localparam int OP_HI = 15;
  localparam int OP_LO = 13;
  localparam int X_HI  = 12;
  localparam int X_LO  = 10;
  localparam int Y_HI  = 9;
  localparam int Y_LO  = 7;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  function automatic logic [2:0] opcode(input logic [15:0] w);
    return w[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/cpu_program_sequencer_watchdog.sv
// seq_watchdog: clearable/loadable cycle counter that flags the enabled cycle
// on which the count reaches its limit.
module seq_watchdog #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                       cnt_d = '0;
    else if (load_i)                 cnt_d = load_val_i;
    else if (en_i && (cnt_q != '1))  cnt_d = cnt_q + W'(1);
  end

  // Expires on the limit-th enabled cycle counted since the last clear.
  assign expired_o = en_i && (cnt_q >= (limit_i - W'(1)));

endmodule

// File: rtl/cpu_program_sequencer.sv
// Fetches instructions (and mvi immediates) from a synchronous ROM and feeds
// them to the bus CPU, with start/halt/abort control and a done watchdog.
module cpu_program_sequencer
  import cpu_program_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic              abort_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [15:0]       mem_rdata_i,
  output logic              cpu_run_o,
  output logic [15:0]       cpu_din_o,
  input  logic              cpu_done_i,
  output logic              busy_o,
  output logic              halted_o,
  output logic              error_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [15:0]       instr_count_o
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       instr_q, instr_d;
  logic [15:0]       imm_q, imm_d;
  logic              run_q, run_d;
  logic [15:0]       din_q, din_d;
  logic              wd_clr, wd_en, wd_exp;
  logic              mvi_q, mvi_d;

  seq_watchdog #(.W(4)) u_wd (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clr_i      (wd_clr),
    .load_i     (1'b0),
    .load_val_i (4'd0),
    .en_i       (wd_en),
    .limit_i    (4'(TIMEOUT)),
    .expired_o  (wd_exp)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      instr_q <= '0;
      imm_q   <= '0;
      run_q   <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      imm_q   <= imm_d;
      run_q   <= run_d;
      din_q   <= din_d;
    end
  end

  assign mvi_q = (opcode(instr_q) == OP_MVI);
  assign mvi_d = (opcode(instr_d) == OP_MVI);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    instr_d    = instr_q;
    imm_d      = imm_q;
    mem_rd_o   = 1'b0;
    mem_addr_o = pc_q;
    wd_clr     = 1'b0;
    wd_en      = 1'b0;

    case (state_q)
      S_IDLE, S_HALTED, S_ERROR: begin
        // abort outranks a simultaneous start
        if (start_i && !abort_i) begin
          state_d = S_FETCH;
          pc_d    = start_addr_i;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        mem_rd_o = 1'b1;
        state_d  = abort_i ? S_IDLE : S_DECODE;
      end
      S_DECODE: begin
        instr_d = mem_rdata_i;
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          case (opcode(mem_rdata_i))
            OP_MVI: begin
              mem_rd_o   = 1'b1;
              mem_addr_o = pc_q + ONE;
              state_d    = S_FETCH_IMM;
            end
            OP_HALT:                state_d = S_HALTED;
            OP_MV, OP_ADD, OP_SUB:  state_d = S_ISSUE;
            default:                state_d = S_ERROR;
          endcase
        end
      end
      S_FETCH_IMM: begin
        imm_d   = mem_rdata_i;
        state_d = abort_i ? S_IDLE : S_ISSUE;
      end
      S_ISSUE: begin
        wd_clr  = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        wd_en = 1'b1;
        if (cpu_done_i) begin
          pc_d    = pc_q + (mvi_q ? TWO : ONE);
          cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          state_d = abort_i ? S_IDLE : S_FETCH;
        end else if (wd_exp) begin
          state_d = S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // CPU-facing outputs are registered from the next state so cpu_done never
  // reaches them combinationally.
  always_comb begin
    run_d = (state_d == S_ISSUE);
    din_d = '0;
    if (state_d == S_ISSUE)     din_d = instr_d;
    else if (state_d == S_EXEC) din_d = mvi_d ? imm_d : instr_d;
  end

  assign cpu_run_o     = run_q;
  assign cpu_din_o     = din_q;
  assign busy_o        = !(state_q inside {S_IDLE, S_HALTED, S_ERROR});
  assign halted_o      = (state_q == S_HALTED);
  assign error_o       = (state_q == S_ERROR);
  assign pc_o          = pc_q;
  assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_cpu_program_sequencer.sv
// Scoreboard bench: stimulus pushes expected CPU issues / terminal events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_cpu_program_sequencer;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 4;
  localparam int K_RUN = 0, K_HALT = 1, K_ERR = 2, K_IDLE = 3;

  typedef struct {
    int          kind;
    logic [15:0] din;
    logic [15:0] exec;
    int          gap;
    logic [7:0]  pc;
    logic [15:0] cnt;
  } ev_t;

  logic        clk = 0, reset = 1, start = 0, abort = 0, cpu_done;
  logic [7:0]  start_addr = 0, mem_addr, pc;
  logic        mem_rd, cpu_run, busy, halted, error;
  logic [15:0] mem_rdata = 0, cpu_din, instr_count;

  logic [15:0] rom [256];
  int          done_at = 2;
  int          ecnt = 0;
  int          cyc = 0;
  int          ntests = 0, nfail = 0;
  ev_t         sb[$];

  cpu_program_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .start_addr_i(start_addr),
    .abort_i(abort), .mem_rd_o(mem_rd), .mem_addr_o(mem_addr),
    .mem_rdata_i(mem_rdata), .cpu_run_o(cpu_run), .cpu_din_o(cpu_din),
    .cpu_done_i(cpu_done), .busy_o(busy), .halted_o(halted), .error_o(error),
    .pc_o(pc), .instr_count_o(instr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM: data one cycle after the read strobe.
  always @(posedge clk) if (mem_rd) mem_rdata <= rom[mem_addr];

  // CPU model: done on the done_at-th EXEC cycle after a run pulse (0 = never).
  always @(posedge clk) begin
    if (cpu_run)       ecnt <= 1;
    else if (cpu_done) ecnt <= 0;
    else if (ecnt != 0) ecnt <= ecnt + 1;
  end
  assign cpu_done = (done_at != 0) && (ecnt == done_at);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [15:0] din, input logic [15:0] ex,
                      input int gap, input logic [7:0] p, input logic [15:0] c);
    ev_t e;
    e.kind = k; e.din = din; e.exec = ex; e.gap = gap; e.pc = p; e.cnt = c;
    sb.push_back(e);
  endtask

  task automatic pop(input string nm, input int kind, output ev_t e, output bit ok);
    ok = 0;
    e.kind = -1; e.din = 0; e.exec = 0; e.gap = 0; e.pc = 0; e.cnt = 0;
    if (sb.size() == 0) begin
      ntests++; nfail++;
      $display("FAIL %s: unexpected event, expected none", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, "_kind"}, e.kind, kind);
      ok = (e.kind == kind);
    end
  endtask

  // Monitor
  bit          prev_busy = 0, prev_h = 0, prev_e = 0, in_exec = 0;
  logic [15:0] exec_exp = 0;
  int          last_run = 0;
  always @(negedge clk) begin
    ev_t e; bit ok;
    if (reset) begin
      prev_busy = 0; prev_h = 0; prev_e = 0; in_exec = 0;
    end else begin
      if (in_exec && busy) chk("exec_din", cpu_din, exec_exp);
      if (in_exec && (cpu_done || !busy)) in_exec = 0;
      if (cpu_run) begin
        pop("run", K_RUN, e, ok);
        if (ok) begin
          chk("run_din", cpu_din, e.din);
          if (e.gap != 0) chk("run_gap", cyc - last_run, e.gap);
          exec_exp = e.exec;
          in_exec  = 1;
        end
        last_run = cyc;
      end
      if (halted && !prev_h) begin
        pop("halt", K_HALT, e, ok);
        if (ok) begin
          chk("halt_pc", pc, e.pc); chk("halt_cnt", instr_count, e.cnt);
          chk("halt_busy", busy, 0);
        end
      end
      if (error && !prev_e) begin
        pop("err", K_ERR, e, ok);
        if (ok) begin
          chk("err_pc", pc, e.pc); chk("err_cnt", instr_count, e.cnt);
          chk("err_busy", busy, 0);
          if (e.gap != 0) chk("err_gap", cyc - last_run, e.gap);
        end
      end
      if (!busy && prev_busy && !halted && !error) begin
        pop("idle", K_IDLE, e, ok);
        if (ok) begin
          chk("idle_pc", pc, e.pc); chk("idle_cnt", instr_count, e.cnt);
        end
      end
      prev_busy = busy; prev_h = halted; prev_e = error;
    end
  end

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hE000;
  endtask

  task automatic start_at(input logic [7:0] a);
    @(negedge clk); start_addr = a; start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 200) begin @(posedge clk); #1; n++; end
    if (busy) begin
      ntests++; nfail++;
      $display("FAIL %s_timeout: busy=%0d after %0d cycles, expected 0", nm, busy, n);
    end
    @(negedge clk); #1;
    chk({nm, "_drain"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_run(input string nm);
    int n = 0;
    while (!cpu_run && n < 50) begin @(posedge clk); #1; n++; end
    if (!cpu_run) begin
      ntests++; nfail++;
      $display("FAIL %s_norun: cpu_run=%0d, expected 1", nm, cpu_run);
    end
  endtask

  initial begin
    int nrd;
    fill_rom();
    repeat (3) @(posedge clk);
    #1 chk("reset_outs", {mem_rd, mem_addr, cpu_run, cpu_din, busy, halted, error, pc, instr_count}, 0);
    @(negedge clk) reset = 0;

    // mvi R0,#5 then halt
    rom[0] = 16'h2000; rom[1] = 16'h0005; rom[2] = 16'hE000;
    push(K_RUN, 16'h2000, 16'h0005, 0, 0, 0);
    push(K_HALT, 0, 0, 0, 8'd2, 16'd1);
    start_at(8'd0);
    wait_idle("mvi");

    // add, sub, halt: run pulses 5 cycles apart
    rom[0] = 16'h4080; rom[1] = 16'h6080; rom[2] = 16'hE000;
    push(K_RUN, 16'h4080, 16'h4080, 0, 0, 0);
    push(K_RUN, 16'h6080, 16'h6080, 5, 0, 0);
    push(K_HALT, 0, 0, 0, 8'd2, 16'd2);
    start_at(8'd0);
    wait_idle("addsub");

    // mvi at the top address wraps to 0 for its immediate
    rom[8'hFF] = 16'h2400; rom[0] = 16'h1234; rom[1] = 16'hE000;
    push(K_RUN, 16'h2400, 16'h1234, 0, 0, 0);
    push(K_HALT, 0, 0, 0, 8'd1, 16'd1);
    start_at(8'hFF);
    wait_idle("wrap");

    // CPU never completes: error after TIMEOUT EXEC cycles (ISSUE + TIMEOUT + 1)
    fill_rom();
    done_at = 0;
    rom[0] = 16'h4080;
    push(K_RUN, 16'h4080, 16'h4080, 0, 0, 0);
    push(K_ERR, 0, 0, TIMEOUT + 1, 8'd0, 16'd0);
    start_at(8'd0);
    wait_idle("timeout");

    // Recovery from ERROR
    done_at = 2;
    rom[1] = 16'hE000;
    push(K_RUN, 16'h4080, 16'h4080, 0, 0, 0);
    push(K_HALT, 0, 0, 0, 8'd1, 16'd1);
    start_at(8'd0);
    wait_idle("recover");
    chk("recover_err", error, 0);

    // Illegal opcode: error, no CPU cycle
    rom[0] = 16'h8000;
    push(K_ERR, 0, 0, 0, 8'd0, 16'd0);
    start_at(8'd0);
    wait_idle("illegal");

    // abort in EXEC: instruction completes, then IDLE, no more fetches
    rom[0] = 16'h4080; rom[1] = 16'h4080;
    push(K_RUN, 16'h4080, 16'h4080, 0, 0, 0);
    push(K_IDLE, 0, 0, 0, 8'd1, 16'd1);
    start_at(8'd0);
    wait_run("abort");
    abort = 1;
    wait_idle("abort");
    nrd = 0;
    start_at(8'd0);  // start together with abort is ignored
    repeat (6) begin @(posedge clk); #1; nrd += mem_rd; end
    chk("abort_no_rd", nrd, 0);
    chk("abort_start_ignored", busy, 0);
    abort = 0;

    // abort in FETCH: straight back to IDLE, no CPU cycle
    rom[5] = 16'h4080;
    push(K_IDLE, 0, 0, 0, 8'd5, 16'd0);
    start_at(8'd5);
    abort = 1;
    wait_idle("abort_fetch");
    abort = 0;

    // Asynchronous reset in EXEC
    push(K_RUN, 16'h4080, 16'h4080, 0, 0, 0);
    start_at(8'd0);
    wait_run("rst");
    @(posedge clk); #1;
    chk("rst_in_exec", dut.state_q, 5);
    reset = 1; #1;
    chk("rst_outs", {mem_rd, mem_addr, cpu_run, cpu_din, busy, halted, error, pc, instr_count}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;
    @(negedge clk); #1;
    chk("rst_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
